// File: rtl/uart_tx_pkg.sv
// Shared constants for the buffered UART transmitter: register map, CTRL/STATUS
// bit positions and the TX state encoding.
package uart_tx_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_PAR_EN   = 1;
  localparam int unsigned CTRL_PAR_ODD  = 2;
  localparam int unsigned CTRL_TWO_STOP = 3;
  localparam int unsigned CTRL_IRQ_EN   = 4;
  localparam int unsigned CTRL_W        = 5;

  localparam logic [CTRL_W-1:0] CTRL_RESET = 5'h01;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_regif_if.sv
// Register-port bundle between software-side master and the UART block.
interface uart_tx_fifo_regif_if #(
  parameter int unsigned DATA_W = 8
);

  logic              wr_en;
  logic              rd_en;
  logic [1:0]        wr_addr;
  logic [1:0]        rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, rd_en, wr_addr, rd_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  wr_en, rd_en, wr_addr, rd_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the oldest entry.
module sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_regif.sv
// Buffered UART transmitter: register decode, TX FIFO and frame serialiser
// with programmable baud divider, optional parity and 1/2 stop bits.
module uart_tx_fifo_regif
  import uart_tx_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FIFO_DEPTH  = 8,
  parameter logic [DATA_W-1:0] DEFAULT_DIV = DATA_W'(15)
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_regif_if.slave  bus,
  output logic                 busy,
  output logic                 uart_tx_done,
  output logic                 tx_irq,
  output logic                 tx_out
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] baud;
  logic              ovf;
  logic [DATA_W-1:0] status;

  logic              wr_txdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              pop;

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] data_l;
  logic [DATA_W-1:0] div_l;
  logic              par_en_l, par_odd_l, two_stop_l;
  logic              load;
  logic              done_n;
  logic              line_n;
  logic              start_ok;

  assign wr_txdata = bus.wr_en && (bus.wr_addr == ADDR_TXDATA);

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = busy;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_FULL]                 = fifo_full;
    status[ST_OVF]                  = ovf;
    status[DATA_W-1:ST_CNT_LSB]     = (DATA_W - ST_CNT_LSB)'(fifo_count);
  end

  // Reads sample pre-write register contents, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl        <= CTRL_RESET;
      baud        <= DEFAULT_DIV;
      ovf         <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      if (bus.rd_en) begin
        case (bus.rd_addr)
          ADDR_CTRL:   bus.rd_data <= DATA_W'(ctrl);
          ADDR_BAUD:   bus.rd_data <= baud;
          ADDR_STATUS: bus.rd_data <= status;
          default:     bus.rd_data <= '0;
        endcase
      end
      if (bus.wr_en && bus.wr_addr == ADDR_CTRL) ctrl <= bus.wr_data[CTRL_W-1:0];
      if (bus.wr_en && bus.wr_addr == ADDR_BAUD) baud <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == ADDR_STATUS && bus.wr_data[ST_OVF]) ovf <= 1'b0;
      if (wr_txdata && fifo_full) ovf <= 1'b1;
    end
  end

  assign tx_irq   = ovf | (ctrl[CTRL_IRQ_EN] & fifo_empty & ~busy);
  assign start_ok = ctrl[CTRL_TX_EN] && !fifo_empty;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    pop     = 1'b0;
    load    = 1'b0;
    done_n  = 1'b0;
    if (state != S_IDLE) cnt_n = cnt - DATA_W'(1);
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = S_START;
          cnt_n   = baud;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          state_n = S_DATA;
          bit_n   = '0;
          cnt_n   = div_l;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_n = div_l;
          if (bit_idx == BIT_W'(DATA_W - 1)) begin
            state_n = par_en_l ? S_PARITY : S_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt == '0) begin
          state_n = S_STOP;
          bit_n   = '0;
          cnt_n   = div_l;
        end
      end
      S_STOP: begin
        // bit_idx doubles as the stop-bit counter in this state.
        if (cnt == '0) begin
          if (two_stop_l && bit_idx == '0) begin
            bit_n = BIT_W'(1);
            cnt_n = div_l;
          end else begin
            done_n = 1'b1;
            if (start_ok) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_n = S_START;
              cnt_n   = baud;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line level is computed for the upcoming state so tx_out lines up with it.
    line_n = 1'b1;
    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = data_l[bit_n];
      S_PARITY: line_n = (^data_l) ^ par_odd_l;
      default:  line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      data_l       <= '0;
      div_l        <= '0;
      par_en_l     <= 1'b0;
      par_odd_l    <= 1'b0;
      two_stop_l   <= 1'b0;
      busy         <= 1'b0;
      uart_tx_done <= 1'b0;
      tx_out       <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      busy         <= (state_n != S_IDLE);
      uart_tx_done <= done_n;
      tx_out       <= line_n;
      if (load) begin
        data_l     <= fifo_dout;
        div_l      <= baud;
        par_en_l   <= ctrl[CTRL_PAR_EN];
        par_odd_l  <= ctrl[CTRL_PAR_ODD];
        two_stop_l <= ctrl[CTRL_TWO_STOP];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_regif.sv
// Bench for uart_tx_fifo_regif: waveform-queue reference model checked every
// cycle, plus directed frame captures with hand-computed expectations.
module tb_uart_tx_fifo_regif;
  import uart_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, uart_tx_done, tx_irq, tx_out;

  uart_tx_fifo_regif_if #(.DATA_W(8)) bus ();

  uart_tx_fifo_regif #(
    .DATA_W      (8),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (8'd15)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .busy         (busy),
    .uart_tx_done (uart_tx_done),
    .tx_irq       (tx_irq),
    .tx_out       (tx_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO as a queue, a frame as a queue of per-clock line levels.
  logic [7:0] m_q[$];
  bit         m_wave[$];
  logic [4:0] m_ctrl = 5'h01;
  logic [7:0] m_baud = 8'd15;
  logic       m_ovf  = 1'b0;
  logic [7:0] m_rd   = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_tx   = 1'b1;
  bit         pre_full, pre_empty, frame_end;

  function automatic logic [7:0] reg_val(logic [1:0] a);
    case (a)
      2'd1:    return {3'b000, m_ctrl};
      2'd2:    return m_baud;
      2'd3:    return {4'(m_q.size()), m_ovf, m_q.size() == 8, m_q.size() == 0, m_busy};
      default: return 8'h00;
    endcase
  endfunction

  function automatic void build_frame(logic [7:0] b);
    bit lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (m_ctrl[1]) lv.push_back((^b) ^ m_ctrl[2]);
    lv.push_back(1'b1);
    if (m_ctrl[3]) lv.push_back(1'b1);
    foreach (lv[i])
      for (int k = 0; k <= int'(m_baud); k++) m_wave.push_back(lv[i]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_wave.delete();
      m_ctrl = 5'h01; m_baud = 8'd15; m_ovf = 1'b0; m_rd = 8'h00;
      m_busy = 1'b0;  m_done = 1'b0;  m_tx  = 1'b1;
    end else begin
      pre_full  = (m_q.size() == 8);
      pre_empty = (m_q.size() == 0);
      if (bus.rd_en) m_rd = reg_val(bus.rd_addr);
      frame_end = 1'b0;
      if (m_wave.size() > 0) begin
        void'(m_wave.pop_front());
        frame_end = (m_wave.size() == 0);
      end
      if (m_wave.size() == 0 && m_ctrl[0] && !pre_empty) build_frame(m_q.pop_front());
      if (bus.wr_en) begin
        case (bus.wr_addr)
          2'd0: if (pre_full) m_ovf = 1'b1; else m_q.push_back(bus.wr_data);
          2'd1: m_ctrl = bus.wr_data[4:0];
          2'd2: m_baud = bus.wr_data;
          default: if (bus.wr_data[3]) m_ovf = 1'b0;
        endcase
        if (bus.wr_addr == 2'd0 && pre_full) m_ovf = 1'b1;
      end
      m_done = frame_end;
      m_busy = (m_wave.size() > 0);
      m_tx   = m_busy ? m_wave[0] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_out", tx_out, m_tx);
      check("busy", busy, m_busy);
      check("uart_tx_done", uart_tx_done, m_done);
      check("tx_irq", tx_irq, m_ovf | (m_ctrl[4] & (m_q.size() == 0) & ~m_busy));
      check("rd_data", bus.rd_data, m_rd);
    end
  end

  // Directed-test helpers; all are entered just after a falling edge.
  logic cap_tx[400], cap_busy[400], cap_done[400];

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    for (int i = 0; i < 1000; i++) begin
      if (busy === lvl) break;
      @(negedge clk);
    end
    check(name, busy, lvl);
  endtask

  task automatic capture(input int n, input int baud_at, input logic [7:0] baud_val);
    for (int i = 0; i < n; i++) begin
      cap_tx[i] = tx_out; cap_busy[i] = busy; cap_done[i] = uart_tx_done;
      bus.wr_en = (i == baud_at); bus.wr_addr = ADDR_BAUD; bus.wr_data = baud_val;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  function automatic int busy_cnt(int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(cap_busy[i]);
    return c;
  endfunction

  function automatic int done_cnt(int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(cap_done[i]);
    return c;
  endfunction

  function automatic int first_done(int n);
    for (int i = 0; i < n; i++) if (cap_done[i]) return i;
    return -1;
  endfunction

  logic [7:0] rv;
  logic [9:0] a5_lv = 10'b1101001010;

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.wr_addr = 2'd0; bus.rd_addr = 2'd0; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_tx_out", tx_out, 1'b1);
    rd(ADDR_STATUS, rv); check("rst_status", rv, 8'h02);
    rd(ADDR_CTRL, rv);   check("rst_ctrl", rv, 8'h01);
    rd(ADDR_BAUD, rv);   check("rst_baud", rv, 8'h0F);

    // Plain 8N1 frame of 0xA5 at 4 clocks/bit
    wr(ADDR_BAUD, 8'd3);
    wr(ADDR_TXDATA, 8'hA5);
    wait_busy(1'b1, "a5_start_timeout");
    capture(48, -1, 8'h00);
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_bit%0d", k), {cap_tx[4*k], cap_tx[4*k+1], cap_tx[4*k+2], cap_tx[4*k+3]},
            {4{a5_lv[k]}});
    check("a5_busy_len", busy_cnt(48), 40);
    check("a5_done_at", first_done(48), 40);
    check("a5_done_cnt", done_cnt(48), 1);

    // Same-cycle read and write return the old register value
    bus.rd_en = 1'b1; bus.rd_addr = ADDR_BAUD;
    wr(ADDR_BAUD, 8'd7);
    bus.rd_en = 1'b0;
    check("rdwr_old", bus.rd_data, 8'h03);
    rd(ADDR_BAUD, rv); check("rdwr_new", rv, 8'h07);
    wr(ADDR_BAUD, 8'd3);

    // Even parity, odd parity, two stop bits
    wr(ADDR_CTRL, 8'h03);
    wr(ADDR_TXDATA, 8'hA5);
    wait_busy(1'b1, "even_start_timeout");
    capture(48, -1, 8'h00);
    check("even_par", {cap_tx[36], cap_tx[37], cap_tx[38], cap_tx[39]}, 4'h0);
    check("even_len", busy_cnt(48), 44);
    wr(ADDR_CTRL, 8'h07);
    wr(ADDR_TXDATA, 8'hA5);
    wait_busy(1'b1, "odd_start_timeout");
    capture(48, -1, 8'h00);
    check("odd_par", {cap_tx[36], cap_tx[37], cap_tx[38], cap_tx[39]}, 4'hF);
    wr(ADDR_CTRL, 8'h09);
    wr(ADDR_TXDATA, 8'hA5);
    wait_busy(1'b1, "stop2_start_timeout");
    capture(48, -1, 8'h00);
    check("stop2_len", busy_cnt(48), 44);
    check("stop2_done_at", first_done(48), 44);
    check("stop2_level", {cap_tx[36], cap_tx[37], cap_tx[38], cap_tx[39],
                          cap_tx[40], cap_tx[41], cap_tx[42], cap_tx[43]}, 8'hFF);

    // Overflow with transmitter disabled, W1C, then back-to-back drain
    wr(ADDR_CTRL, 8'h00);
    for (int i = 1; i <= 9; i++) wr(ADDR_TXDATA, 8'(i * 17));
    rd(ADDR_STATUS, rv); check("ovf_status", rv, 8'h8C);
    check("ovf_irq", tx_irq, 1'b1);
    wr(ADDR_STATUS, 8'h08);
    rd(ADDR_STATUS, rv); check("ovf_cleared", rv, 8'h84);
    wr(ADDR_CTRL, 8'h01);
    wait_busy(1'b1, "burst_start_timeout");
    capture(340, -1, 8'h00);
    check("burst_busy_len", busy_cnt(340), 320);
    check("burst_done_cnt", done_cnt(340), 8);
    check("burst_busy_end", cap_busy[319], 1'b1);
    check("burst_idle_end", cap_busy[320], 1'b0);

    // Interrupt on empty and idle
    wr(ADDR_CTRL, 8'h11);
    check("irq_idle_empty", tx_irq, 1'b1);
    wr(ADDR_TXDATA, 8'h3C);
    check("irq_after_push", tx_irq, 1'b0);
    wait_busy(1'b1, "irq_start_timeout");
    wait_busy(1'b0, "irq_end_timeout");
    check("irq_after_frame", tx_irq, 1'b1);
    wr(ADDR_TXDATA, 8'h5A);
    check("irq_deassert", tx_irq, 1'b0);
    wait_busy(1'b1, "irq2_start_timeout");
    wait_busy(1'b0, "irq2_end_timeout");

    // Asynchronous reset in the middle of the data bits
    wr(ADDR_CTRL, 8'h01);
    wr(ADDR_TXDATA, 8'h00);
    wait_busy(1'b1, "rst_frame_timeout");
    repeat (12) @(negedge clk);
    check("pre_rst_tx_low", tx_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx", tx_out, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", uart_tx_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(ADDR_STATUS, rv); check("post_rst_status", rv, 8'h02);
    rd(ADDR_CTRL, rv);   check("post_rst_ctrl", rv, 8'h01);
    rd(ADDR_BAUD, rv);   check("post_rst_baud", rv, 8'h0F);

    // Divider change mid-frame applies to the following frame only
    wr(ADDR_BAUD, 8'd3);
    wr(ADDR_TXDATA, 8'h0F);
    wr(ADDR_TXDATA, 8'hF0);
    wait_busy(1'b1, "baud_start_timeout");
    capture(70, 10, 8'd1);
    check("baud_busy_len", busy_cnt(70), 60);
    check("baud_first_done", first_done(70), 40);
    check("baud_second_done", cap_done[60], 1'b1);
    check("baud_frame1_bits", {cap_tx[20], cap_tx[19]}, 2'b01);
    check("baud_frame2_bits", {cap_tx[51], cap_tx[50], cap_tx[49], cap_tx[48]}, 4'b1100);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
